// File: rtl/float_add_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// float_add_arbiter : round-robin sharing of one pipelined FloatAdder, with drain
// Revision 1.0
// ----------------------------------------------------------------------------
module float_add_arbiter #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 23,
   parameter int NUM_REQ        = 4,
   parameter int ADDER_LATENCY  = 3
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [NUM_REQ-1:0]                           req_valid,
   output logic [NUM_REQ-1:0]                           req_ready,
   input  logic [NUM_REQ*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_a,
   input  logic [NUM_REQ*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_b,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]       add_a,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]       add_b,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]       add_sum,
   output logic [NUM_REQ-1:0]                           resp_valid,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]       resp_sum,
   input  logic                                         flush_req,
   output logic                                         flush_done,
   output logic                                         busy
);
   localparam int W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(ADDER_LATENCY + 1);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    grant_idx;
   logic [IW-1:0]    cand_idx;
   logic             grant_any;
   int               cand;
   logic [W-1:0]     a_arr [NUM_REQ];
   logic [W-1:0]     b_arr [NUM_REQ];
   logic [ADDER_LATENCY-1:0] tag_vld;
   logic [IW-1:0]    tag_idx [ADDER_LATENCY];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*W +: W];
      assign b_arr[i] = req_b[i*W +: W];
   end

   // Scan from the highest offset down so the requester closest to ptr wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      if (state == RUN && !flush_req && !rst) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (req_valid[cand_idx]) begin
               grant_any = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
      req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      flush_done = 1'b0;
      case (state)
         RUN: begin
            if (flush_req) begin
               state_nxt = DRAIN;
               cnt_nxt   = CW'(ADDER_LATENCY);
            end
         end
         DRAIN: begin
            if (cnt == '0) begin
               flush_done = 1'b1;
               state_nxt  = RUN;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         cnt        <= '0;
         ptr        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         tag_vld    <= '0;
         resp_valid <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant_any) begin
            ptr   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            add_a <= a_arr[grant_idx];
            add_b <= b_arr[grant_idx];
         end
         for (int s = ADDER_LATENCY - 1; s > 0; s--) begin
            tag_vld[s] <= tag_vld[s-1];
         end
         tag_vld[0] <= grant_any;
         // Final stage lines the strobe up with the adder's result cycle.
         resp_valid <= tag_vld[ADDER_LATENCY-1] ? (NUM_REQ'(1) << tag_idx[ADDER_LATENCY-1]) : '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int s = ADDER_LATENCY - 1; s > 0; s--) begin
         tag_idx[s] <= tag_idx[s-1];
      end
      tag_idx[0] <= grant_idx;
   end

   assign resp_sum = (|resp_valid) ? add_sum : '0;
   assign busy     = |tag_vld;

endmodule
`default_nettype wire
